// File: rtl/lane_vehicle_counter.sv
// Four-approach vehicle counter: each raw detector is synchronised, debounced and
// edge-qualified, then counted per window and snapshotted onto the *_num outputs.

// Per-lane front end: two-flop synchroniser plus debounce FSM.
// state | meaning
// IDLE  | synchronised input low, waiting for a new high period
// ARM   | input high, counting consecutive high cycles toward DEB
// HELD  | vehicle already counted, waiting for the input to drop
module lane_vehicle_counter_lane #(
  parameter int DEB = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_det,
  output logic o_qual
);

  localparam int HW = (DEB > 2) ? $clog2(DEB) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    HELD = 2'd2
  } lane_state_t;

  logic [1:0]  r_sync;
  lane_state_t r_state;
  logic [HW-1:0] r_hcnt;
  logic        w_s;

  assign w_s = r_sync[1];

  // Qualify fires on the edge where the high run reaches DEB cycles.
  always_comb begin
    o_qual = 1'b0;
    case (r_state)
      IDLE:    o_qual = w_s && (DEB == 1);
      ARM:     o_qual = w_s && (r_hcnt == HW'(DEB - 1));
      default: o_qual = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync  <= 2'b00;
      r_state <= IDLE;
      r_hcnt  <= '0;
    end else begin
      r_sync <= {r_sync[0], i_det};
      case (r_state)
        IDLE: begin
          if (w_s) begin
            r_hcnt  <= HW'(1);
            r_state <= (DEB == 1) ? HELD : ARM;
          end
        end
        ARM: begin
          if (!w_s) begin
            r_state <= IDLE;
          end else if (o_qual) begin
            r_state <= HELD;
          end else begin
            r_hcnt <= r_hcnt + 1'b1;
          end
        end
        HELD: begin
          if (!w_s) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

module lane_vehicle_counter #(
  parameter int WINDOW = 16,
  parameter int DEB    = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       main_det,
  input  logic       left_det,
  input  logic       sec_det,
  input  logic       p_det,
  output logic [2:0] main_num,
  output logic [2:0] left_num,
  output logic [2:0] sec_num,
  output logic [2:0] p_num,
  output logic       snap_valid
);

  localparam int WW = (WINDOW > 2) ? $clog2(WINDOW) : 1;

  logic [3:0]    w_det;
  logic [3:0]    w_qual;
  logic [2:0]    w_acc_next [4];
  logic          w_win_end;
  logic [WW-1:0] r_win_cnt;
  logic [2:0]    r_acc [4];
  logic [2:0]    r_num [4];
  logic          r_snap_valid;

  function automatic logic [2:0] sat_inc(input logic [2:0] a, input logic q);
    return (q && (a != 3'd7)) ? a + 3'd1 : a;
  endfunction

  assign w_det = {p_det, sec_det, left_det, main_det};

  for (genvar g = 0; g < 4; g++) begin : g_lane
    lane_vehicle_counter_lane #(.DEB(DEB)) u_lane (
      .clk    (clk),
      .rst    (rst),
      .i_det  (w_det[g]),
      .o_qual (w_qual[g])
    );
  end

  assign w_win_end = (r_win_cnt == WW'(WINDOW - 1));

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      w_acc_next[i] = sat_inc(r_acc[i], w_qual[i]);
    end
  end

  // A qualify landing on the closing edge is folded into that window's snapshot.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_win_cnt    <= '0;
      r_snap_valid <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        r_acc[i] <= 3'd0;
        r_num[i] <= 3'd0;
      end
    end else begin
      r_snap_valid <= w_win_end;
      r_win_cnt    <= w_win_end ? '0 : r_win_cnt + 1'b1;
      for (int i = 0; i < 4; i++) begin
        if (w_win_end) begin
          r_num[i] <= w_acc_next[i];
          r_acc[i] <= 3'd0;
        end else begin
          r_acc[i] <= w_acc_next[i];
        end
      end
    end
  end

  assign main_num   = r_num[0];
  assign left_num   = r_num[1];
  assign sec_num    = r_num[2];
  assign p_num      = r_num[3];
  assign snap_valid = r_snap_valid;

endmodule

// File: tb/tb_lane_vehicle_counter.sv
// Directed bench for lane_vehicle_counter: a WINDOW=16 and a WINDOW=64 instance,
// expected snapshots queued at stimulus time and compared on each snap_valid.
module tb_lane_vehicle_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic main_det, left_det, sec_det, p_det;
  logic [2:0] main_num, left_num, sec_num, p_num;
  logic snap_valid;

  logic m64_det, l64_det, s64_det, p64_det;
  logic [2:0] m64_num, l64_num, s64_num, p64_num;
  logic snap64;

  lane_vehicle_counter u_dut (
    .clk(clk), .rst(rst),
    .main_det(main_det), .left_det(left_det), .sec_det(sec_det), .p_det(p_det),
    .main_num(main_num), .left_num(left_num), .sec_num(sec_num), .p_num(p_num),
    .snap_valid(snap_valid)
  );

  lane_vehicle_counter #(.WINDOW(64)) u_dut64 (
    .clk(clk), .rst(rst),
    .main_det(m64_det), .left_det(l64_det), .sec_det(s64_det), .p_det(p64_det),
    .main_num(m64_num), .left_num(l64_num), .sec_num(s64_num), .p_num(p64_num),
    .snap_valid(snap64)
  );

  typedef struct packed {
    logic [2:0] m;
    logic [2:0] l;
    logic [2:0] s;
    logic [2:0] p;
  } snap_t;

  snap_t q16[$];
  snap_t q64[$];
  int n_vec  = 0;
  int n_fail = 0;
  int waited;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic snap_t mk(input int m, input int l, input int s, input int p);
    snap_t r;
    r.m = 3'(m);
    r.l = 3'(l);
    r.s = 3'(s);
    r.p = 3'(p);
    return r;
  endfunction

  // Waits (bounded) for the next snapshot pulse of one instance, then pops and compares.
  task automatic wait_snap(input string tag, input bit is64, input int budget, output int n);
    logic sv;
    snap_t e;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      sv = is64 ? snap64 : snap_valid;
    end while (sv !== 1'b1 && n < budget);
    check({tag, ".snap"}, {7'd0, sv}, 8'd1);
    e = is64 ? q64.pop_front() : q16.pop_front();
    check({tag, ".main"}, is64 ? m64_num : main_num, e.m);
    check({tag, ".left"}, is64 ? l64_num : left_num, e.l);
    check({tag, ".sec"},  is64 ? s64_num : sec_num,  e.s);
    check({tag, ".p"},    is64 ? p64_num : p_num,    e.p);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    main_det = 1'b1; left_det = 1'b1; sec_det = 1'b1; p_det = 1'b1;
    m64_det = 1'b0; l64_det = 1'b0; s64_det = 1'b0; p64_det = 1'b0;

    // Reset held three cycles with every detector high.
    tick(3);
    check("rst.main", main_num, 0);
    check("rst.left", left_num, 0);
    check("rst.sec",  sec_num,  0);
    check("rst.p",    p_num,    0);
    check("rst.snap", snap_valid, 0);
    rst = 1'b0;

    // W1: detectors stay high -> each lane counts exactly once, simultaneously.
    q16.push_back(mk(1, 1, 1, 1));
    wait_snap("w1", 1'b0, 24, waited);
    check("w1.latency", waited, 16);
    main_det = 1'b0; left_det = 1'b0; sec_det = 1'b0; p_det = 1'b0;
    tick(1);
    check("w1.pulse_width", snap_valid, 0);
    check("w1.hold_main", main_num, 1);
    check("w1.hold_p", p_num, 1);

    // W2: quiet window; the held-high periods from W1 are not recounted.
    q16.push_back(mk(0, 0, 0, 0));
    wait_snap("w2", 1'b0, 24, waited);

    // W3: five single-cycle glitches on left never qualify.
    for (int i = 0; i < 5; i++) begin
      left_det = 1'b1; tick(1);
      left_det = 1'b0; tick(1);
    end
    q16.push_back(mk(0, 0, 0, 0));
    wait_snap("w3", 1'b0, 24, waited);

    // W4: one two-cycle pulse on left qualifies.
    left_det = 1'b1; tick(2);
    left_det = 1'b0;
    q16.push_back(mk(0, 1, 0, 0));
    wait_snap("w4", 1'b0, 24, waited);

    // W5: p qualifies on the closing edge of the window.
    tick(12);
    p_det = 1'b1;
    q16.push_back(mk(0, 0, 0, 1));
    wait_snap("w5", 1'b0, 24, waited);

    // W6: p still high (no recount); main arms just before the boundary.
    tick(13);
    main_det = 1'b1; tick(2);
    main_det = 1'b0; p_det = 1'b0;
    q16.push_back(mk(0, 0, 0, 0));
    wait_snap("w6", 1'b0, 24, waited);

    // W7: the straddling main arm counts here, plus one fresh pulse.
    main_det = 1'b1; tick(2);
    main_det = 1'b0;
    q16.push_back(mk(2, 0, 0, 0));
    wait_snap("w7", 1'b0, 24, waited);

    // W8: partial main count, then reset sampled while win_cnt==9.
    main_det = 1'b1; tick(2);
    main_det = 1'b0; tick(1);
    main_det = 1'b1; tick(2);
    main_det = 1'b0; tick(1);
    main_det = 1'b1; tick(2);
    main_det = 1'b0; tick(1);
    rst = 1'b1;
    tick(1);
    check("rst2.main", main_num, 0);
    check("rst2.left", left_num, 0);
    check("rst2.sec",  sec_num,  0);
    check("rst2.p",    p_num,    0);
    check("rst2.snap", snap_valid, 0);
    tick(1);
    check("rst2.snap_hold", snap_valid, 0);
    rst = 1'b0;
    q16.push_back(mk(0, 0, 0, 0));
    wait_snap("w8", 1'b0, 24, waited);
    check("w8.latency", waited, 16);

    // WINDOW=64 instance: align to its window first.
    q64.push_back(mk(0, 0, 0, 0));
    wait_snap("x0", 1'b1, 80, waited);

    // Three 4-high/4-low main pulses in one window.
    for (int i = 0; i < 3; i++) begin
      m64_det = 1'b1; tick(4);
      m64_det = 1'b0; tick(4);
    end
    q64.push_back(mk(3, 0, 0, 0));
    wait_snap("x1", 1'b1, 80, waited);

    // Ten valid secondary pulses saturate at 7.
    for (int i = 0; i < 10; i++) begin
      s64_det = 1'b1; tick(2);
      s64_det = 1'b0; tick(1);
    end
    q64.push_back(mk(0, 0, 7, 0));
    wait_snap("x2", 1'b1, 80, waited);

    // Following window is empty.
    q64.push_back(mk(0, 0, 0, 0));
    wait_snap("x3", 1'b1, 80, waited);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
